output_sram_write_arbiter: RTL

OUTPUT_SRAM_WRITE_ARBITER -- requirements
Module: output_sram_write_arbiter

---
 rtl/output_sram_write_arbiter.sv | 183 ++++++++++++++++++
 1 files changed

// File: rtl/output_sram_write_arbiter.sv
// output_sram_write_arbiter: round-robin arbiter that streams one bank buffer's
// feature-vector beats into the output SRAM, two words per row.
module output_sram_write_arbiter #(
    parameter int NUM_BANKS     = 4,
    parameter int FV_SIZE       = 16,
    parameter int MAX_FV_NUM    = 16,
    parameter int MAX_NODE_ID   = 64,
    parameter int GRANT_TIMEOUT = 16,
    localparam int BEATS  = MAX_FV_NUM / 2,
    localparam int NID_W  = $clog2(MAX_NODE_ID),
    localparam int ADDR_W = $clog2(MAX_NODE_ID * BEATS)
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic [NUM_BANKS-1:0]             bank_req,
    input  logic [NUM_BANKS-1:0]             bank_valid,
    input  logic [NUM_BANKS-1:0]             bank_sos,
    input  logic [NUM_BANKS-1:0]             bank_eos,
    input  logic [NUM_BANKS*2*FV_SIZE-1:0]   bank_data,
    input  logic [NUM_BANKS*NID_W-1:0]       bank_nodeid,
    output logic [NUM_BANKS-1:0]             bank_grant,
    output logic                             sram_wen,
    output logic [ADDR_W-1:0]                sram_addr,
    output logic [2*FV_SIZE-1:0]             sram_wdata,
    output logic                             wr_done,
    output logic                             err,
    output logic                             busy
);
    localparam int IW = NUM_BANKS > 1 ? $clog2(NUM_BANKS) : 1;
    localparam int BW = BEATS > 1 ? $clog2(BEATS) : 1;
    localparam int CW = $clog2(GRANT_TIMEOUT + 1);

    typedef enum logic [1:0] {IDLE, WAIT_SOS, XFER} state_t;

    state_t                state_q, state_d;
    logic [IW-1:0]         last_q, last_d;
    logic [NUM_BANKS-1:0]  grant_q, grant_d;
    logic [NID_W-1:0]      nid_q, nid_d;
    logic [BW-1:0]         beat_q, beat_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic                  wen_q, wen_d;
    logic [ADDR_W-1:0]     addr_q, addr_d;
    logic [2*FV_SIZE-1:0]  wdata_q, wdata_d;
    logic                  done_q, done_d;
    logic                  err_q, err_d;

    logic [IW-1:0]         sel;
    logic                  found;
    logic                  gv, gs, ge;
    logic [2*FV_SIZE-1:0]  gdata;
    logic [NID_W-1:0]      gnid;
    logic [BW-1:0]         nbeat;

    function automatic logic [ADDR_W-1:0] addr_of(input logic [NID_W-1:0] n, input logic [BW-1:0] b);
        return ADDR_W'(n) * ADDR_W'(BEATS) + ADDR_W'(b);
    endfunction

    // last_q holds the bank chosen most recently, so it doubles as the granted index
    assign gv    = bank_valid[last_q];
    assign gs    = bank_sos[last_q];
    assign ge    = bank_eos[last_q];
    assign nbeat = beat_q + 1'b1;

    always_comb begin
        gdata = '0;
        gnid  = '0;
        for (int b = 0; b < NUM_BANKS; b++) begin
            if (IW'(b) == last_q) begin
                gdata = bank_data[b*2*FV_SIZE +: 2*FV_SIZE];
                gnid  = bank_nodeid[b*NID_W +: NID_W];
            end
        end
    end

    always_comb begin
        sel   = last_q;
        found = 1'b0;
        for (int k = 1; k <= NUM_BANKS; k++) begin
            if (!found && bank_req[IW'((int'(last_q) + k) % NUM_BANKS)]) begin
                found = 1'b1;
                sel   = IW'((int'(last_q) + k) % NUM_BANKS);
            end
        end
    end

    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        grant_d = grant_q;
        nid_d   = nid_q;
        beat_d  = beat_q;
        cnt_d   = cnt_q;
        wen_d   = 1'b0;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        done_d  = 1'b0;
        err_d   = err_q;
        case (state_q)
            IDLE: begin
                if (|bank_req) begin
                    state_d = WAIT_SOS;
                    last_d  = sel;
                    grant_d = NUM_BANKS'(1) << sel;
                    cnt_d   = '0;
                end
            end
            WAIT_SOS: begin
                if (gv && gs) begin
                    nid_d   = gnid;
                    beat_d  = '0;
                    wen_d   = 1'b1;
                    addr_d  = addr_of(gnid, '0);
                    wdata_d = gdata;
                    done_d  = ge;
                    grant_d = ge ? '0 : grant_q;
                    state_d = ge ? IDLE : XFER;
                end else if (cnt_q == CW'(GRANT_TIMEOUT - 1)) begin
                    err_d   = 1'b1;
                    grant_d = '0;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            XFER: begin
                if (gv) begin
                    err_d = err_q | gs;
                    // a beat past the last row would spill into the next node's rows
                    if (beat_q == BW'(BEATS - 1)) begin
                        err_d   = 1'b1;
                        grant_d = '0;
                        state_d = IDLE;
                    end else begin
                        beat_d  = nbeat;
                        wen_d   = 1'b1;
                        addr_d  = addr_of(nid_q, nbeat);
                        wdata_d = gdata;
                        done_d  = ge;
                        grant_d = ge ? '0 : grant_q;
                        state_d = ge ? IDLE : XFER;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            last_q  <= IW'(NUM_BANKS - 1);
            grant_q <= '0;
            nid_q   <= '0;
            beat_q  <= '0;
            cnt_q   <= '0;
            wen_q   <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            grant_q <= grant_d;
            nid_q   <= nid_d;
            beat_q  <= beat_d;
            cnt_q   <= cnt_d;
            wen_q   <= wen_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    assign bank_grant = grant_q;
    assign sram_wen   = wen_q;
    assign sram_addr  = addr_q;
    assign sram_wdata = wdata_q;
    assign wr_done    = done_q;
    assign err        = err_q;
    assign busy       = state_q != IDLE;
endmodule
